product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream consumer of the Multiplier stage. Takes a valid/ready stream of
//  unsigned 2N-bit products and sums them over a frame. A frame ends on in_last
//  or after MAX_LEN beats. Emits the frame sum, beat count and a sticky overflow
//  flag on a valid/ready output. Forms the accumulate half of a sequential
//  multiply-accumulate path.
// PARAMETERS
//  N        8   multiplier operand width; products are 2N bits
//  GUARD    8   extra accumulator bits; ACC_W = 2N + GUARD
//  MAX_LEN  16  max beats per frame (>=1); CNT_W = $clog2(MAX_LEN+1)
// PORTS
//  clk           in   1      single clock, rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  in_valid      in   1      in_product/in_last valid
//  in_ready      out  1      block accepts a beat; =1 only in ACCUM state
//  in_product    in   2N     unsigned product from Multiplier
//  in_last       in   1      beat closes the frame
//  clear         in   1      synchronous frame abort
//  out_valid     out  1      frame result valid
//  out_ready     in   1      downstream accepts result
//  out_sum       out  ACC_W  frame sum, modulo 2^ACC_W
//  out_count     out  CNT_W  beats accumulated in frame
//  out_overflow  out  1      carry out of ACC_W occurred during frame
// BEHAVIOUR
//  - Reset (async): state=ACCUM; acc, count, out_sum, out_count = 0;
//    out_overflow = 0; out_valid = 0. in_ready is 1 as soon as reset releases.
//  - Beat accepted when in_valid & in_ready. Then acc += zero-extended product,
//    count += 1, and overflow |= carry out of ACC_W.
//  - End of frame: the accepted beat has in_last=1 or makes count==MAX_LEN.
//    The next cycle: out_valid=1, outputs carry the final acc/count/overflow,
//    state=HOLD. Latency is 1 cycle from the final beat to out_valid.
//  - HOLD: in_ready=0. Outputs stay stable while out_valid & !out_ready.
//    On the out handshake: acc/count/overflow clear, out_valid=0 next cycle,
//    state=ACCUM. There is no same-cycle bypass, so a beat offered in the
//    handshake cycle is not taken.
//  - States: ACCUM -(end-of-frame beat)-> HOLD -(out_valid&out_ready)-> ACCUM.
//    clear forces ACCUM from either state.
//  - clear has highest priority. acc/count/overflow zero next cycle. out_valid
//    drops next cycle, and a held result is discarded. A beat presented in the
//    clear cycle is dropped, even though in_ready is 1.
//  - Arithmetic is unsigned. The sum wraps modulo 2^ACC_W. The overflow flag is
//    sticky until the frame is handed off or cleared. An in_product of zero
//    still counts as a beat.
//  - Reset mid-frame or mid-HOLD: immediate return to reset values, and the
//    result is lost.
// STRUCTURE
//  - accum_pkg holds: state_t enum {ACCUM, HOLD}; functions acc_w(N,GUARD) and
//    cnt_w(MAX_LEN).
//  - One sub-module, accum_adder: ACC_W-bit add with carry out. It is
//    combinational and sits between the acc register and its next value.
//  - The FSM, counter and output registers live in the top module.
// TESTING (N=8, GUARD=8, MAX_LEN=16 unless noted)
//  1. Beats 10, 20, 30 with in_last on the 3rd -> one cycle later out_valid=1,
//     out_sum=60, out_count=3, out_overflow=0.
//  2. 16 beats of 0xFFFF, no in_last -> frame closes on the 16th beat;
//     out_sum=0x0FFFF0, out_count=16, out_overflow=0.
//  3. GUARD=2 (ACC_W=18), 5 beats of 0xFFFF with last -> out_sum=65531,
//     out_overflow=1. The next frame (beat 1 with last) -> out_sum=1,
//     out_overflow=0.
//  4. Backpressure: hold out_ready=0 for 5 cycles after out_valid ->
//     out_sum/out_count stable, in_ready=0, offered beats are not consumed.
//     Then out_ready=1 -> in_ready=1 the following cycle.
//  5. Beats 5, 9, then clear with in_valid=1 (beat 100), then beat 7 with last
//     -> out_sum=7, out_count=1. The 100 is never summed.
//  6. Deassert reset_n asynchronously while in HOLD -> out_valid=0 and
//     out_sum=0 before the next clk edge. After release, in_ready=1.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared state encoding and width helpers for the product accumulator.
package accum_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic int acc_w(input int n, input int guard);
      return 2 * n + guard;
   endfunction

   function automatic int cnt_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, frame result out; the accumulator sits on the slave side.
interface product_accumulator_if #(
   parameter int N       = 8,
   parameter int GUARD   = 8,
   parameter int MAX_LEN = 16
);
   import accum_pkg::*;

   localparam int ACC_W = acc_w(N, GUARD);
   localparam int CNT_W = cnt_w(MAX_LEN);

   logic             in_valid;
   logic             in_ready;
   logic [2*N-1:0]   in_product;
   logic             in_last;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_overflow;

   modport master (
      output in_valid, in_product, in_last, clear, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_overflow
   );

   modport slave (
      input  in_valid, in_product, in_last, clear, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_overflow
   );

endinterface

// File: rtl/accum_adder.sv
// Unsigned ACC_W-bit adder exposing the carry out used for the sticky overflow.
module accum_adder #(
   parameter int ACC_W = 24
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/product_accumulator.sv
// Sums a valid/ready stream of products per frame and presents the frame total,
// beat count and overflow flag until downstream takes it.
module product_accumulator
   import accum_pkg::*;
#(
   parameter int N       = 8,
   parameter int GUARD   = 8,
   parameter int MAX_LEN = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   product_accumulator_if.slave bus
);

   localparam int ACC_W = acc_w(N, GUARD);
   localparam int CNT_W = cnt_w(MAX_LEN);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [CNT_W-1:0] cnt_inc;
   logic             frame_end;

   accum_adder #(.ACC_W(ACC_W)) u_adder (
      .a     (acc_q),
      .b     (ACC_W'(bus.in_product)),
      .sum   (add_sum),
      .carry (add_carry)
   );

   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign frame_end = bus.in_last || (cnt_inc == CNT_W'(MAX_LEN));

   always_comb begin
      // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      // clear beats everything, including a beat offered in the same cycle.
      if (bus.clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (bus.in_valid) begin
                  acc_d = add_sum;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | add_carry;
                  if (frame_end) state_d = HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // The accumulator registers double as the result registers while in HOLD.
   assign bus.in_ready     = (state_q == ACCUM);
   assign bus.out_valid    = (state_q == HOLD);
   assign bus.out_sum      = acc_q;
   assign bus.out_count    = cnt_q;
   assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised frames on a GUARD=8 and a GUARD=2 accumulator, checked against a
// plain-arithmetic frame model, plus directed clear, backpressure and reset cases.
module tb_product_accumulator;

   logic clk;
   logic reset_n;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit             in_ready;
      bit             out_valid;
      longint unsigned sum;
      int             count;
      bit             ovf;
   } obs_t;

   product_accumulator_if #(.N(8), .GUARD(8), .MAX_LEN(16)) ifa ();
   product_accumulator_if #(.N(8), .GUARD(2), .MAX_LEN(16)) ifb ();

   product_accumulator #(.N(8), .GUARD(8), .MAX_LEN(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifa)
   );

   product_accumulator #(.N(8), .GUARD(2), .MAX_LEN(16)) dut_g2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame result from the arithmetic definition: true sum wraps modulo 2^accw,
   // and at least one carry happened exactly when the true sum reaches 2^accw.
   function automatic void ref_frame(input int unsigned beats[$], input int accw,
                                     output longint unsigned sum, output bit ovf);
      longint unsigned total;
      total = 0;
      foreach (beats[i]) total += longint'(beats[i]);
      sum = total % (64'd1 << accw);
      ovf = (total >> accw) != 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input bit sel, input bit v, input int unsigned p, input bit l, input bit r);
      if (sel) begin
         ifb.in_valid = v; ifb.in_product = 16'(p); ifb.in_last = l; ifb.out_ready = r;
      end else begin
         ifa.in_valid = v; ifa.in_product = 16'(p); ifa.in_last = l; ifa.out_ready = r;
      end
   endtask

   function automatic obs_t peek(input bit sel);
      obs_t o;
      if (sel) begin
         o.in_ready = ifb.in_ready; o.out_valid = ifb.out_valid; o.sum = 64'(ifb.out_sum);
         o.count = int'(ifb.out_count); o.ovf = ifb.out_overflow;
      end else begin
         o.in_ready = ifa.in_ready; o.out_valid = ifa.out_valid; o.sum = 64'(ifa.out_sum);
         o.count = int'(ifa.out_count); o.ovf = ifa.out_overflow;
      end
      return o;
   endfunction

   task automatic run_frame(input bit sel, input int unsigned beats[$], input bit with_last);
      foreach (beats[i]) begin
         if ($urandom_range(0, 3) == 0) begin
            put(sel, 1'b0, 0, 1'b0, 1'b0);
            tick();
         end
         put(sel, 1'b1, beats[i], with_last && (i == beats.size() - 1), 1'b0);
         tick();
      end
      put(sel, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // Checks the presented result, stalls for 'hold' cycles offering junk beats,
   // then completes the handshake (with a beat offered that must be ignored).
   task automatic check_result(input bit sel, input int unsigned beats[$], input int hold);
      longint unsigned esum;
      bit              eovf;
      obs_t            o;
      ref_frame(beats, sel ? 18 : 24, esum, eovf);
      o = peek(sel);
      check("result out_valid", o.out_valid, 1);
      check("result out_sum", o.sum, esum);
      check("result out_count", o.count, beats.size());
      check("result out_overflow", o.ovf, eovf);
      for (int c = 0; c < hold; c++) begin
         put(sel, 1'b1, $urandom_range(1, 65535), 1'b0, 1'b0);
         tick();
         o = peek(sel);
         check("hold in_ready", o.in_ready, 0);
         check("hold out_valid", o.out_valid, 1);
         check("hold out_sum", o.sum, esum);
         check("hold out_count", o.count, beats.size());
      end
      put(sel, 1'b1, $urandom_range(1, 65535), 1'b0, 1'b1);
      tick();
      put(sel, 1'b0, 0, 1'b0, 1'b0);
      o = peek(sel);
      check("handoff out_valid", o.out_valid, 0);
      check("handoff in_ready", o.in_ready, 1);
   endtask

   initial begin
      int unsigned beats[$];
      obs_t        o;
      bit          wl;
      int          len;

      reset_n = 1'b0;
      ifa.clear = 1'b0;
      ifb.clear = 1'b0;
      put(1'b0, 1'b0, 0, 1'b0, 1'b0);
      put(1'b1, 1'b0, 0, 1'b0, 1'b0);
      #8;
      o = peek(1'b0);
      check("reset out_valid", o.out_valid, 0);
      check("reset out_sum", o.sum, 0);
      check("reset out_count", o.count, 0);
      check("reset out_overflow", o.ovf, 0);
      #4 reset_n = 1'b1;
      #1;
      check("post-reset in_ready", ifa.in_ready, 1);
      tick();

      // Short frame closed by in_last.
      beats = '{10, 20, 30};
      run_frame(1'b0, beats, 1'b1);
      check("t1 out_sum literal", ifa.out_sum, 60);
      check_result(1'b0, beats, 0);

      // MAX_LEN beats without in_last close the frame on the last one.
      beats = {};
      for (int i = 0; i < 16; i++) beats.push_back(32'hFFFF);
      run_frame(1'b0, beats, 1'b0);
      check("t2 out_sum literal", ifa.out_sum, 24'h0FFFF0);
      check_result(1'b0, beats, 1);

      // Backpressure for 5 cycles; the next frame must not contain offered junk.
      beats = '{1234, 0, 4321};
      run_frame(1'b0, beats, 1'b1);
      check_result(1'b0, beats, 5);
      beats = '{1};
      run_frame(1'b0, beats, 1'b1);
      check_result(1'b0, beats, 0);

      // clear mid-frame drops the partial sum and the beat offered with it.
      beats = '{5, 9};
      run_frame(1'b0, beats, 1'b0);
      put(1'b0, 1'b1, 100, 1'b0, 1'b0);
      ifa.clear = 1'b1;
      tick();
      ifa.clear = 1'b0;
      put(1'b0, 1'b0, 0, 1'b0, 1'b0);
      beats = '{7};
      run_frame(1'b0, beats, 1'b1);
      check("t5 out_sum literal", ifa.out_sum, 7);
      check_result(1'b0, beats, 0);

      // clear while holding a result discards it.
      beats = '{3};
      run_frame(1'b0, beats, 1'b1);
      check("clear-hold pre out_valid", ifa.out_valid, 1);
      ifa.clear = 1'b1;
      tick();
      ifa.clear = 1'b0;
      check("clear-hold out_valid", ifa.out_valid, 0);
      check("clear-hold in_ready", ifa.in_ready, 1);
      beats = '{4};
      run_frame(1'b0, beats, 1'b1);
      check_result(1'b0, beats, 0);

      // Randomised frames on the wide accumulator.
      for (int f = 0; f < 20; f++) begin
         beats = {};
         len = $urandom_range(1, 16);
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 7))
               0, 1:    beats.push_back(32'hFFFF);
               2:       beats.push_back(0);
               default: beats.push_back($urandom_range(0, 65535));
            endcase
         end
         wl = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         run_frame(1'b0, beats, wl);
         check_result(1'b0, beats, $urandom_range(0, 3));
      end

      // Narrow accumulator: wrap and sticky overflow, then a clean frame.
      beats = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'hFFFF};
      run_frame(1'b1, beats, 1'b1);
      check("t3 out_sum literal", ifb.out_sum, 65531);
      check("t3 out_overflow literal", ifb.out_overflow, 1);
      check_result(1'b1, beats, 0);
      beats = '{1};
      run_frame(1'b1, beats, 1'b1);
      check("t3 next out_overflow", ifb.out_overflow, 0);
      check_result(1'b1, beats, 0);

      for (int f = 0; f < 10; f++) begin
         beats = {};
         len = $urandom_range(1, 8);
         for (int i = 0; i < len; i++) beats.push_back($urandom_range(32'h8000, 32'hFFFF));
         run_frame(1'b1, beats, 1'b1);
         check_result(1'b1, beats, $urandom_range(0, 2));
      end

      // Asynchronous reset while holding a result.
      beats = '{50, 60};
      run_frame(1'b0, beats, 1'b1);
      check("t6 pre out_valid", ifa.out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t6 async out_valid", ifa.out_valid, 0);
      check("t6 async out_sum", ifa.out_sum, 0);
      check("t6 async out_count", ifa.out_count, 0);
      #2 reset_n = 1'b1;
      #1;
      check("t6 release in_ready", ifa.in_ready, 1);
      tick();
      beats = '{11, 22};
      run_frame(1'b0, beats, 1'b1);
      check_result(1'b0, beats, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
